afe_ro_ring_buffer: RTL and testbench

Multi-channel SRAM-backed circular sample buffer for the AFE readout subsystem; parametrised successor of the single-port readout SRAM buffer. One shared 32-bit single-port SRAM is partitioned into NUM_CH equal rings of DEPTH words. Each ring has its own write/read pointers, fill count and sticky overflow flag. AFE sample writes are never stalled; CPU/uDMA pops are served in the remaining SRAM cycles.

---
 rtl/afe_ro_buf_pkg.sv | 9 +
 rtl/afe_ro_buf_ch_ctrl.sv | 76 +++++++
 rtl/sram_wrapper_32b.sv | 26 ++
 rtl/afe_ro_ring_buffer.sv | 115 +++++++++++
 tb/tb_afe_ro_ring_buffer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_ro_buf_pkg.sv
// Shared helpers for the AFE readout ring buffer.
package afe_ro_buf_pkg;

  // A single channel still needs a 1-bit channel select field.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/afe_ro_buf_ch_ctrl.sv
// Per-channel ring state: pointers, fill, sticky overflow, optional watermark irq.
// Watermark comparator only exists with AFE_RO_RING_BUF_WMARK_EN defined.
module afe_ro_buf_ch_ctrl
  import afe_ro_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [CNT_W-1:0] wmark_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] fill_o,
  output logic             ovf_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             irq_o
);

  typedef struct packed {
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill;
    logic             ovf;
  } ch_state_t;

  ch_state_t state_q, state_d;

  assign full_o  = (state_q.fill == CNT_W'(DEPTH));
  assign empty_o = (state_q.fill == '0);

  // Clear beats write/pop; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = '0;
    end else if (wr_i) begin
      if (full_o) begin
        state_d.ovf = 1'b1;
      end else begin
        state_d.wr_ptr = state_q.wr_ptr + 1'b1;
        state_d.fill   = state_q.fill + 1'b1;
      end
    end else if (rd_i && !empty_o) begin
      state_d.rd_ptr = state_q.rd_ptr + 1'b1;
      state_d.fill   = state_q.fill - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= '0;
    else         state_q <= state_d;
  end

  assign wr_ptr_o = state_q.wr_ptr;
  assign rd_ptr_o = state_q.rd_ptr;
  assign fill_o   = state_q.fill;
  assign ovf_o    = state_q.ovf;

`ifdef AFE_RO_RING_BUF_WMARK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_o <= 1'b0;
    else         irq_o <= (wmark_i != '0) && (state_d.fill >= wmark_i);
  end
`else
  logic unused_wmark;
  assign unused_wmark = ^wmark_i;
  assign irq_o = 1'b0;
`endif

endmodule

// File: rtl/sram_wrapper_32b.sv
// Behavioural 32-bit single-port SRAM: active-low chip/write/bit enables, 1-cycle read.
module sram_wrapper_32b #(
  parameter int unsigned ADDR_WIDTH = 10
)(
  input  logic                  clk_i,
  input  logic                  ce_ni,
  input  logic                  we_ni,
  input  logic [31:0]           bwe_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!ce_ni) begin
      if (!we_ni) begin
        mem[addr_i] <= (mem[addr_i] & bwe_ni) | (wdata_i & ~bwe_ni);
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/afe_ro_ring_buffer.sv
// Multi-channel ring buffer over one shared single-port SRAM; writes own the SRAM.
// Optional watermark interrupt: define AFE_RO_RING_BUF_WMARK_EN.
module afe_ro_ring_buffer
  import afe_ro_buf_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned DEPTH      = 256,
  localparam int unsigned CH_W       = ch_width(NUM_CH),
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
)(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_valid_i,
  input  logic [CH_W-1:0]         wr_ch_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_req_i,
  input  logic [CH_W-1:0]         rd_ch_i,
  output logic                    rd_gnt_o,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  output logic                    rd_err_o,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH*CNT_W-1:0] fill_o,
  output logic [NUM_CH-1:0]       ovf_o,
  input  logic [CNT_W-1:0]        wmark_i,
  output logic [NUM_CH-1:0]       irq_o
);

  localparam int unsigned ADDR_WIDTH = $clog2(NUM_CH * DEPTH);
  localparam int unsigned FULL_AW    = CH_W + PTR_W;
  localparam logic [32:0] DATA_MASK  = (33'd1 << DATA_WIDTH) - 33'd1;

  logic [PTR_W-1:0] wr_ptr [NUM_CH];
  logic [PTR_W-1:0] rd_ptr [NUM_CH];
  logic [CNT_W-1:0] fill   [NUM_CH];
  logic [NUM_CH-1:0] full, empty, wr_en, rd_en;

  logic            wr_in_range, rd_in_range, sram_wr, sram_rd;
  logic [CH_W-1:0] wr_idx, rd_idx;
  logic [FULL_AW-1:0] addr_full;
  logic [31:0]     sram_rdata;
  logic            rvalid_q, err_q, hit_q;

  assign wr_in_range = (32'(wr_ch_i) < NUM_CH);
  assign rd_in_range = (32'(rd_ch_i) < NUM_CH);
  assign wr_idx      = wr_in_range ? wr_ch_i : '0;
  assign rd_idx      = rd_in_range ? rd_ch_i : '0;

  assign rd_gnt_o = rd_req_i & ~wr_valid_i;

  // SRAM is touched only by an accepted write or a pop that really dequeues.
  assign sram_wr = wr_valid_i & wr_in_range & ~full[wr_idx] & ~clr_i[wr_idx];
  assign sram_rd = rd_gnt_o & rd_in_range & ~empty[rd_idx] & ~clr_i[rd_idx];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_en[c] = wr_valid_i & (wr_ch_i == CH_W'(c));
    assign rd_en[c] = rd_gnt_o & (rd_ch_i == CH_W'(c));

    afe_ro_buf_ch_ctrl #(
      .DEPTH (DEPTH)
    ) u_ch_ctrl (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clr_i[c]),
      .wr_i     (wr_en[c]),
      .rd_i     (rd_en[c]),
      .wmark_i  (wmark_i),
      .wr_ptr_o (wr_ptr[c]),
      .rd_ptr_o (rd_ptr[c]),
      .fill_o   (fill[c]),
      .ovf_o    (ovf_o[c]),
      .full_o   (full[c]),
      .empty_o  (empty[c]),
      .irq_o    (irq_o[c])
    );

    assign fill_o[c*CNT_W +: CNT_W] = fill[c];
  end

  assign addr_full = sram_wr ? {wr_idx, wr_ptr[wr_idx]} : {rd_idx, rd_ptr[rd_idx]};

  sram_wrapper_32b #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk_i   (clk_i),
    .ce_ni   (~(sram_wr | sram_rd)),
    .we_ni   (~sram_wr),
    .bwe_ni  (~DATA_MASK[31:0]),
    .addr_i  (addr_full[ADDR_WIDTH-1:0]),
    .wdata_i (32'(wr_data_i)),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_gnt_o;
      err_q    <= rd_gnt_o & ~sram_rd;
      hit_q    <= sram_rd;
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^sram_rdata;

  assign rd_rvalid_o = rvalid_q;
  assign rd_err_o    = err_q;
  assign rd_rdata_o  = hit_q ? sram_rdata[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_afe_ro_ring_buffer.sv
// Self-checking bench: per-channel queue model, every-cycle compare, directed + random stimulus.
module tb_afe_ro_ring_buffer;

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned DEP = 16;
  localparam int unsigned CHW = 2;
  localparam int unsigned CW  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic [CHW-1:0]   wr_ch = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             rd_req = 1'b0;
  logic [CHW-1:0]   rd_ch = '0;
  logic             rd_gnt, rd_rvalid, rd_err;
  logic [DW-1:0]    rd_rdata;
  logic [NCH-1:0]   clr = '0;
  logic [NCH*CW-1:0] fill;
  logic [NCH-1:0]   ovf, irq;
  logic [CW-1:0]    wmark = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  afe_ro_ring_buffer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .DEPTH      (DEP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_ch_i     (wr_ch),
    .wr_data_i   (wr_data),
    .rd_req_i    (rd_req),
    .rd_ch_i     (rd_ch),
    .rd_gnt_o    (rd_gnt),
    .rd_rvalid_o (rd_rvalid),
    .rd_rdata_o  (rd_rdata),
    .rd_err_o    (rd_err),
    .clr_i       (clr),
    .fill_o      (fill),
    .ovf_o       (ovf),
    .wmark_i     (wmark),
    .irq_o       (irq)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned mq [NCH][$];
  bit          movf [NCH];
  bit          mirq [NCH];
  bit          exp_rvalid, exp_err;
  int unsigned exp_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        movf[c] = 1'b0;
        mirq[c] = 1'b0;
      end
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = 0;
    end else begin
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = 0;
      if (rd_req && !wr_valid) begin
        exp_rvalid = 1'b1;
        if (clr[rd_ch] || mq[rd_ch].size() == 0) exp_err = 1'b1;
        else exp_rdata = mq[rd_ch].pop_front();
      end
      if (wr_valid && !clr[wr_ch]) begin
        if (mq[wr_ch].size() == DEP) movf[wr_ch] = 1'b1;
        else mq[wr_ch].push_back(int'(wr_data));
      end
      for (int c = 0; c < NCH; c++) begin
        if (clr[c]) begin
          mq[c].delete();
          movf[c] = 1'b0;
        end
`ifdef AFE_RO_RING_BUF_WMARK_EN
        mirq[c] = (wmark != 0) && (mq[c].size() >= int'(wmark));
`else
        mirq[c] = 1'b0;
`endif
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", rd_gnt, rd_req & ~wr_valid);
      chk("rvalid", rd_rvalid, exp_rvalid);
      if (exp_rvalid) begin
        chk("rerr", rd_err, exp_err);
        chk("rdata", rd_rdata, exp_rdata);
      end
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("fill%0d", c), fill[c*CW +: CW], mq[c].size());
        chk($sformatf("ovf%0d", c), ovf[c], movf[c]);
        chk($sformatf("irq%0d", c), irq[c], mirq[c]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1; wr_ch = CHW'(ch); wr_data = DW'(d);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pop(input int ch);
    rd_req = 1'b1; rd_ch = CHW'(ch);
    step();
    rd_req = 1'b0;
  endtask

  function automatic int fill_of(input int ch);
    return int'(fill[ch*CW +: CW]);
  endfunction

  initial begin
    bit g;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", rd_rvalid, 0);
    chk("rst_rdata", rd_rdata, 0);
    rst_n = 1'b1;
    step();

    // Basic write/pop ordering on ch1
    wr(1, 'hA); wr(1, 'hB); wr(1, 'hC);
    chk("t1_fill3", fill_of(1), 3);
    pop(1); chk("t1_d0", rd_rdata, 'hA); chk("t1_err0", rd_err, 0);
    pop(1); chk("t1_d1", rd_rdata, 'hB);
    pop(1); chk("t1_d2", rd_rdata, 'hC); chk("t1_rv", rd_rvalid, 1);
    chk("t1_fill0", fill_of(1), 0);
    step();
    chk("t1_rv_one", rd_rvalid, 0);

    // Overflow on ch0 with pointers offset so pops cross the wrap
    for (int i = 0; i < 3; i++) wr(0, 'h900 + i);
    for (int i = 0; i < 3; i++) pop(0);
    for (int i = 0; i < DEP + 2; i++) wr(0, 'h100 + i);
    chk("t2_full", fill_of(0), DEP);
    chk("t2_ovf", ovf[0], 1);
    pop(0); chk("t2_first", rd_rdata, 'h100);
    for (int i = 1; i < DEP; i++) pop(0);
    chk("t2_last", rd_rdata, 'h100 + DEP - 1);
    chk("t2_empty", fill_of(0), 0);
    chk("t2_ovf_sticky", ovf[0], 1);

    // Write priority starves a held pop
    rd_req = 1'b1; rd_ch = 1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_ch = 1; wr_data = DW'('h50 + i);
      #1 chk("t3_nognt", rd_gnt, 0);
      step();
    end
    wr_valid = 1'b0;
    #1 chk("t3_gnt", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    chk("t3_data", rd_rdata, 'h50);

    // Pop of empty ch2
    pop(2);
    chk("t4_rv", rd_rvalid, 1); chk("t4_err", rd_err, 1);
    chk("t4_data", rd_rdata, 0); chk("t4_fill", fill_of(2), 0);

    // Clear beats a same-cycle write on ch3
    for (int i = 0; i < 5; i++) wr(3, 'h30 + i);
    chk("t5_fill5", fill_of(3), 5);
    clr = 4'b1000;
    wr(3, 'h3F);
    clr = '0;
    chk("t5_fill0", fill_of(3), 0); chk("t5_ovf", ovf[3], 0);
    chk("t5_ch1", fill_of(1), 4);
    wr(3, 'h77); pop(3); chk("t5_fresh", rd_rdata, 'h77);

    // Watermark irq on ch1
    clr = 4'b0010; step(); clr = '0;
    wmark = 4;
    for (int i = 0; i < 3; i++) wr(1, i);
`ifdef AFE_RO_RING_BUF_WMARK_EN
    chk("t6_irq_lo", irq[1], 0);
    wr(1, 3); chk("t6_irq_hi", irq[1], 1);
    pop(1); chk("t6_irq_pop", irq[1], 0);
    wmark = 0;
    wr(1, 4); wr(1, 5); chk("t6_irq_w0", irq[1], 0);
`else
    wr(1, 3); chk("t6_irq_off", irq, 0);
`endif

    // Randomised traffic; pops hold until granted
    g = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      int wp;
      wp = ((n / 500) % 2 == 1) ? 75 : 30;
      wr_valid = ($urandom_range(0, 99) < wp);
      wr_ch    = CHW'($urandom_range(0, NCH - 1));
      wr_data  = DW'($urandom);
      if (g) begin
        rd_req = ($urandom_range(0, 99) < 50);
        rd_ch  = CHW'($urandom_range(0, NCH - 1));
      end
      clr = ($urandom_range(0, 99) < 3) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
      if (n % 400 == 0) wmark = CW'($urandom_range(0, DEP));
      g = !rd_req || !wr_valid;
      step();
    end
    wr_valid = 1'b0; rd_req = 1'b0; clr = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
